// File: rtl/pipe_reg.sv
// Elastic multi-stage pipeline register with valid/ready handshake and bubble collapsing.
// Each stage advances whenever any stage downstream of it can make room.
module pipe_reg #(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         flush,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic             chain;
   logic             go;

   assign go        = en && !flush;
   assign in_ready  = go && rdy[0];
   assign out_valid = go && v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

   // Ready ripples from the output end; a stage is ready if it or anything after it is empty.
   always_comb begin
      chain          = !v[DEPTH-1] || out_ready;
      rdy            = '0;
      rdy[DEPTH-1]   = chain;
      for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
         chain  = !v[i] || chain;
         rdy[i] = chain;
      end
   end

   always_comb begin
      src_v    = '0;
      src_v[0] = in_valid && in_ready;
      src_d[0] = in_data;
      for (int i = 1; i < int'(DEPTH); i++) begin
         src_v[i] = v[i-1];
         src_d[i] = d[i-1];
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         count = count + CW'(v[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            d[i] <= RESET_VAL;
         end
      end else if (flush) begin
         v <= '0;
      end else if (en) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (rdy[i]) begin
               v[i] <= src_v[i];
               // A bubble clears the valid bit but leaves the old payload in place.
               if (src_v[i]) begin
                  d[i] <= src_d[i];
               end
            end
         end
      end
   end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, legal range >=1.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal range >=1.
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into every stage data register on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  global enable; 0 = freeze all stages.
REQ-007 flush  input  1  synchronous clear of all stage valid bits.
REQ-008 in_valid  input  1  upstream offers in_data.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 in_ready  output  1  pipe accepts in_data this cycle.
REQ-011 out_valid  output  1  out_data holds a valid item.
REQ-012 out_data  output  WIDTH  payload of last stage.
REQ-013 out_ready  input  1  downstream accepts out_data.
REQ-014 count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-015 Each stage i (0..DEPTH-1) SHALL hold a valid bit v[i] and a data register d[i]; stage 0 is the input end, stage DEPTH-1 drives out_data.
REQ-016 Stage ready SHALL be combinational: rdy[DEPTH-1] = !v[DEPTH-1] || out_ready; rdy[i] = !v[i] || rdy[i+1] (bubble collapsing).
REQ-017 in_ready SHALL equal en && !flush && rdy[0].
REQ-018 out_valid SHALL equal en && !flush && v[DEPTH-1]; out_data SHALL always equal d[DEPTH-1].
REQ-019 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-020 When en=1, flush=0 and rdy[i]=1, stage i SHALL load from stage i-1 (or from the input for i=0), taking v from the source's valid (in_valid && in_ready for stage 0) and d from the source's data.
REQ-021 When rdy[i]=0, stage i SHALL hold v[i] and d[i].
REQ-022 d[i] SHALL load only when the incoming valid is 1; a bubble moving in SHALL clear v[i] and leave d[i] unchanged.
REQ-023 en=0 with flush=0 SHALL hold all v and d; no transfer in either direction.
REQ-024 flush=1 at a rising edge SHALL clear all v[i] regardless of en, in_valid and out_ready; d registers are held; no item is accepted or delivered in that cycle.
REQ-025 Latency: an item accepted in cycle t on an empty, non-stalled pipe SHALL present out_valid=1 in cycle t+DEPTH.
REQ-026 Throughput: with out_ready=1 and en=1 continuously, one item SHALL be accepted and one delivered per cycle once full, with order preserved and no loss or duplication.
REQ-027 Full pipe (all v=1) with out_ready=0 SHALL drive in_ready=0; a simultaneous out_ready=1 SHALL allow a same-cycle accept (in_ready=1).
REQ-028 count SHALL equal the population count of v[] and SHALL never exceed DEPTH.
REQ-029 DEPTH=1 SHALL behave as a single full-throughput register stage, with in_ready = en && !flush && (!v[0] || out_ready).

Reset
REQ-030 rst=1 SHALL immediately, without a clock edge, clear all v[i] to 0 and set all d[i] to RESET_VAL; hence out_valid=0, count=0, out_data=RESET_VAL.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight items; the first accept after deassertion SHALL occur no earlier than the first rising edge with rst=0.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=0)
REQ-032 Reset: drive rst=1 between edges -> out_valid=0, count=0, out_data=0x00 before the next edge.
REQ-033 Latency: empty pipe, in_data=0xA5 accepted in cycle 0, out_ready=1 -> out_valid=1, out_data=0xA5 in cycle 3; count=1 in cycles 1-3.
REQ-034 Streaming: feed 0x01..0x10 back-to-back with out_ready=1 -> the same 16 values exit in order, one per cycle starting at cycle 3; in_ready held at 1.
REQ-035 Backpressure: fill with 0x11,0x22,0x33 and out_ready=0 -> count=3, in_ready=0; assert out_ready=1 with in_valid=1, in_data=0x44 -> 0x11 delivered and 0x44 accepted in the same cycle.
REQ-036 Stall/flush: with 2 items in flight, en=0 for 4 cycles -> count stays 2, out_valid=0; then flush=1 for one edge -> count=0, out_valid=0, and an item offered that cycle is not accepted.
REQ-037 Bubble collapse: items at stages 0 and 2 only, out_ready=0 -> the stage-0 item advances to stage 1 on the next edge and in_ready remains 1.
